pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a five-stage pipeline: it handles load-use stalls, taken-branch
// flushes, and memory-wait freezes, and it also selects operand forwarding and keeps stall/flush statistics.
module pipeline_hazard_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] id_rn,
   input  logic [3:0] id_rm,
   input  logic       id_uses_rn,
   input  logic       id_uses_rm,
   input  logic [3:0] ex_rn,
   input  logic [3:0] ex_rm,
   input  logic [3:0] ex_rd,
   input  logic       ex_regwrite,
   input  logic       ex_memread,
   input  logic [3:0] mem_rd,
   input  logic       mem_regwrite,
   input  logic [3:0] wb_rd,
   input  logic       wb_regwrite,
   input  logic       ex_branch_taken,
   input  logic       mem_req,
   input  logic       mem_ready,
   input  logic       cnt_clr,
   output logic       pc_write,
   output logic       ifid_write,
   output logic       idex_write,
   output logic       exmem_write,
   output logic       memwb_write,
   output logic       ifid_flush,
   output logic       idex_flush,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b,
   output logic [1:0] state,
   output logic [15:0] stall_cycles,
   output logic [7:0] flush_count
);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      LDSTALL = 2'b01,
      FLUSH   = 2'b10,
      MEMWAIT = 2'b11
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] stall_q, stall_d;
   logic [7:0]  flush_q, flush_d;

   logic memWait;
   logic loadUse;
   logic branchFlush;
   logic loadUseStall;

   // ex_regwrite is not needed for the hazard decision itself because a load always writes its
   // destination. R15 is the PC, and it never participates in load-use or forwarding.
   logic unusedRegwrite;
   assign unusedRegwrite = ex_regwrite;

   assign loadUse = ex_memread && (ex_rd != 4'hF) &&
                    ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_rm && (id_rm == ex_rd)));

   // Once the FSM is in MEMWAIT, only the completion strobe releases it, so mem_req is ignored there.
   assign memWait      = (state_q == MEMWAIT) ? !mem_ready : (mem_req && !mem_ready);
   assign branchFlush  = ex_branch_taken && (state_q != FLUSH);
   assign loadUseStall = loadUse && ((state_q == RUN) || (state_q == MEMWAIT));

   always_comb begin
      state_d     = state_q;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      if (reset) begin
         state_d = RUN;
      end else if (memWait) begin
         state_d = MEMWAIT;
      end else if (branchFlush) begin
         pc_write    = 1'b1;
         ifid_write  = 1'b1;
         idex_write  = 1'b1;
         exmem_write = 1'b1;
         memwb_write = 1'b1;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         state_d     = FLUSH;
      end else if (loadUseStall) begin
         idex_write  = 1'b1;
         exmem_write = 1'b1;
         memwb_write = 1'b1;
         idex_flush  = 1'b1;
         state_d     = LDSTALL;
      end else begin
         pc_write    = 1'b1;
         ifid_write  = 1'b1;
         idex_write  = 1'b1;
         exmem_write = 1'b1;
         memwb_write = 1'b1;
         state_d     = RUN;
      end
   end

   // Statistics: ifid_flush is raised only by a taken branch, so it marks a flush event.
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (cnt_clr) begin
         stall_d = 16'h0000;
         flush_d = 8'h00;
      end else begin
         if (!pc_write && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'h0001;
         end
         if (ifid_flush) begin
            flush_d = flush_q + 8'h01;
         end
      end
   end

   // EX/MEM has priority over MEM/WB because it holds the younger result.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (!reset) begin
         if (mem_regwrite && (mem_rd == ex_rn) && (mem_rd != 4'hF)) begin
            fwd_a = 2'b10;
         end else if (wb_regwrite && (wb_rd == ex_rn) && (wb_rd != 4'hF)) begin
            fwd_a = 2'b01;
         end
         if (mem_regwrite && (mem_rd == ex_rm) && (mem_rd != 4'hF)) begin
            fwd_b = 2'b10;
         end else if (wb_regwrite && (wb_rd == ex_rm) && (wb_rd != 4'hF)) begin
            fwd_b = 2'b01;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         stall_q <= 16'h0000;
         flush_q <= 8'h00;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign state        = state_q;
   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic, checked against
// a model that reasons about what the pipeline does each cycle.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] id_rn, id_rm, ex_rn, ex_rm, ex_rd, mem_rd, wb_rd;
   logic       id_uses_rn, id_uses_rm, ex_regwrite, ex_memread;
   logic       mem_regwrite, wb_regwrite, ex_branch_taken, mem_req, mem_ready, cnt_clr;
   logic       pc_write, ifid_write, idex_write, exmem_write, memwb_write;
   logic       ifid_flush, idex_flush;
   logic [1:0] fwd_a, fwd_b, state;
   logic [15:0] stall_cycles;
   logic [7:0] flush_count;

   int totalChecks = 0;
   int badChecks   = 0;

   localparam int NONE = 0, STALLED = 1, FLUSHED = 2, WAITING = 3;
   localparam int ADVANCE = 0, FREEZE = 1, BUBBLE = 2, SQUASH = 3, RESETTING = 4;

   int mLast  = NONE;
   int mStall = 0;
   int mFlush = 0;

   pipeline_hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
      .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
      .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
      .exmem_write(exmem_write), .memwb_write(memwb_write),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // This decides what the pipeline should do in this cycle, given what happened in the previous cycle.
   function automatic int predictAction();
      bit waiting, hazard;
      if (reset) return RESETTING;
      waiting = (mLast == WAITING) ? !mem_ready : (mem_req && !mem_ready);
      hazard  = ex_memread && ex_rd != 15 &&
                ((id_uses_rn && id_rn == ex_rd) || (id_uses_rm && id_rm == ex_rd));
      if (waiting) return FREEZE;
      if (ex_branch_taken && mLast != FLUSHED) return SQUASH;
      if (hazard && (mLast == NONE || mLast == WAITING)) return BUBBLE;
      return ADVANCE;
   endfunction

   // Bit order: pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush
   function automatic logic [6:0] ctrlFor(input int action);
      case (action)
         ADVANCE: return 7'b11111_00;
         BUBBLE:  return 7'b00111_01;
         SQUASH:  return 7'b11111_11;
         default: return 7'b00000_00;
      endcase
   endfunction

   function automatic logic [1:0] fwdFor(input logic [3:0] src);
      if (reset) return 2'b00;
      if (mem_regwrite && mem_rd == src && mem_rd != 15) return 2'b10;
      if (wb_regwrite && wb_rd == src && wb_rd != 15) return 2'b01;
      return 2'b00;
   endfunction

   task automatic runCycle(input bit doCheck);
      int act;
      logic [6:0] ctrl;
      #1;
      act  = predictAction();
      ctrl = ctrlFor(act);
      if (doCheck) begin
         checkOutput("ctrl", {pc_write, ifid_write, idex_write, exmem_write, memwb_write,
                              ifid_flush, idex_flush}, ctrl);
         checkOutput("fwdA", fwd_a, fwdFor(ex_rn));
         checkOutput("fwdB", fwd_b, fwdFor(ex_rm));
      end
      @(posedge clk);
      if (act == RESETTING) begin
         mLast = NONE; mStall = 0; mFlush = 0;
      end else begin
         case (act)
            FREEZE:  mLast = WAITING;
            SQUASH:  mLast = FLUSHED;
            BUBBLE:  mLast = STALLED;
            default: mLast = NONE;
         endcase
         if (cnt_clr) begin
            mStall = 0; mFlush = 0;
         end else begin
            if (!ctrl[6] && mStall < 65535) mStall = mStall + 1;
            if (act == SQUASH) mFlush = (mFlush + 1) % 256;
         end
      end
      #1;
      if (doCheck) begin
         checkOutput("state", state, mLast);
         checkOutput("stall", stall_cycles, mStall);
         checkOutput("flush", flush_count, mFlush);
      end
      @(negedge clk);
   endtask

   task automatic setQuiet();
      reset = 0; cnt_clr = 0;
      id_rn = 0; id_rm = 0; id_uses_rn = 0; id_uses_rm = 0;
      ex_rn = 0; ex_rm = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
      mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
      ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
   endtask

   function automatic logic [3:0] pickReg();
      return ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
   endfunction

   task automatic applyStimulus();
      reset           = ($urandom_range(0, 49) == 0);
      cnt_clr         = ($urandom_range(0, 39) == 0);
      id_rn           = pickReg();
      id_rm           = pickReg();
      id_uses_rn      = 1'($urandom_range(0, 1));
      id_uses_rm      = 1'($urandom_range(0, 1));
      ex_rn           = pickReg();
      ex_rm           = pickReg();
      ex_rd           = pickReg();
      ex_regwrite     = 1'($urandom_range(0, 1));
      ex_memread      = ($urandom_range(0, 2) == 0);
      mem_rd          = pickReg();
      mem_regwrite    = 1'($urandom_range(0, 1));
      wb_rd           = pickReg();
      wb_regwrite     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_req         = ($urandom_range(0, 4) == 0);
      mem_ready       = 1'($urandom_range(0, 1));
   endtask

   initial begin
      setQuiet();
      reset = 1;
      @(negedge clk);
      runCycle(1);
      runCycle(1);
      reset = 0;
      runCycle(1);

      // Load-use stall, then the masked cycle that follows it
      ex_memread = 1; ex_rd = 3; id_rn = 3; id_uses_rn = 1;
      runCycle(1);
      checkOutput("ldState", state, 1);
      checkOutput("ldStallCnt", stall_cycles, 1);
      checkOutput("ldNextEnables", {pc_write, ifid_write, idex_flush}, 3'b110);
      runCycle(1);

      // Branch beats a simultaneous load-use
      ex_branch_taken = 1;
      runCycle(1);
      checkOutput("brState", state, 2);
      checkOutput("brFlushCnt", flush_count, 1);
      checkOutput("brStallCnt", stall_cycles, 1);

      // Memory wait with a branch held high throughout
      setQuiet();
      cnt_clr = 1;
      runCycle(1);
      cnt_clr = 0;
      mem_req = 1; ex_branch_taken = 1;
      repeat (3) runCycle(1);
      checkOutput("mwStallCnt", stall_cycles, 3);
      checkOutput("mwState", state, 3);
      checkOutput("mwFlushCnt", flush_count, 0);
      mem_ready = 1;
      runCycle(1);
      checkOutput("mwReleaseState", state, 2);
      checkOutput("mwReleaseFlush", flush_count, 1);

      // Forwarding priority and the R15 exclusion
      setQuiet();
      mem_rd = 5; wb_rd = 5; mem_regwrite = 1; wb_regwrite = 1; ex_rn = 5;
      #1 checkOutput("fwdMem", fwd_a, 2'b10);
      mem_regwrite = 0;
      #1 checkOutput("fwdWb", fwd_a, 2'b01);
      mem_rd = 15; wb_rd = 15; mem_regwrite = 1;
      #1 checkOutput("fwdR15", fwd_a, 2'b00);
      @(negedge clk);

      // Reset in the middle of a memory wait
      setQuiet();
      cnt_clr = 1;
      runCycle(1);
      cnt_clr = 0; mem_req = 1;
      repeat (7) runCycle(1);
      checkOutput("rstPreStall", stall_cycles, 7);
      reset = 1;
      runCycle(1);
      checkOutput("rstState", state, 0);
      checkOutput("rstStall", stall_cycles, 0);
      setQuiet();
      runCycle(1);

      // Saturation of the stall counter, then a clear that wins over a concurrent stall
      mem_req = 1;
      repeat (65540) runCycle(0);
      runCycle(1);
      checkOutput("stallSat", stall_cycles, 16'hFFFF);
      cnt_clr = 1;
      runCycle(1);
      checkOutput("clrDuringStall", stall_cycles, 0);
      cnt_clr = 0; mem_ready = 1;
      runCycle(1);

      // 256 branch flushes wrap the flush counter back to zero
      setQuiet();
      cnt_clr = 1;
      runCycle(1);
      cnt_clr = 0;
      for (int i = 0; i < 256; i++) begin
         ex_branch_taken = 1;
         runCycle(1);
         ex_branch_taken = 0;
         runCycle(1);
      end
      checkOutput("flushWrap", flush_count, 0);

      repeat (3000) begin
         applyStimulus();
         runCycle(1);
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
